// File: rtl/dpram_rw_be_pkg.sv
// Shared types and the byte-lane merge helper for the dual-port RAM with byte enables.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
// Contents: rdw_mode_e, dpram_state_e, MERGE_MAX_W, be_merge().
package dpram_pkg;

  // Read-during-write result on a same-address collision.
  typedef enum logic {
    RDW_OLD_DATA,
    RDW_NEW_DATA
  } rdw_mode_e;

  // Clear sequencer states.
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } dpram_state_e;

  // Widest word be_merge can handle; callers zero-extend into it and truncate the result.
  localparam int MERGE_MAX_W = 1024;

  // Lane i of the result comes from new_word when be[i] is set, otherwise from old_word.
  // A lane is byte_width bits wide; the write path and the new-data bypass both use this.
  function automatic logic [MERGE_MAX_W-1:0] be_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] be,
    input int                     byte_width
  );
    logic [MERGE_MAX_W-1:0] merged;
    logic [9:0]             lane;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_W; i++) begin
      lane = 10'(i / byte_width);
      if (be[lane]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_rw_be_if.sv
// Read/write port bundle of the dual-port RAM with byte enables.
// Latency: n/a (wiring only).
// Backpressure: none; busy tells the master that both ports are being ignored.
// Ports: busy, rd_en/rd_addr/rd_data/rd_valid, wr_en/wr_be/wr_addr/wr_data.
interface dpram_rw_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_DEPTH = 256
);
  localparam int AW   = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int BE_W = DATA_WIDTH / BYTE_WIDTH;

  logic                  busy;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [BE_W-1:0]       wr_be;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  busy, rd_data, rd_valid,
    output rd_en, rd_addr, wr_en, wr_be, wr_addr, wr_data
  );

  modport slave (
    output busy, rd_data, rd_valid,
    input  rd_en, rd_addr, wr_en, wr_be, wr_addr, wr_data
  );
endinterface

// File: rtl/dpram_clr_seq.sv
// Post-reset clear sequencer: walks every address once, then releases the RAM.
// Latency: DATA_DEPTH cycles from rst falling to busy low.
// Backpressure: busy high for the whole sweep; the RAM ignores both user ports meanwhile.
// Ports: clk, rst in; busy, clr_we, clr_addr out.
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

  dpram_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        // Memory must stay untouched while reset is held.
        clr_we = !rst;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/dpram_rw_be.sv
// Simple dual-port RAM (1R/1W, one clock) with byte-lane write enables and a post-reset clear.
// Latency: 1-cycle read, 2 cycles when DPRAM_RW_BE_OUTREG_EN is defined (extra output register).
// Backpressure: none in run state; busy high during the clear sweep, when both ports are ignored.
// Ports: clk, rst (sync, active-high), bus (slave: busy, rd_en/rd_addr/rd_data/rd_valid,
//        wr_en/wr_be/wr_addr/wr_data). Out-of-range reads return CLEAR_VAL, writes are dropped.
module dpram_rw_be
  import dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    DATA_DEPTH = 256,
  parameter rdw_mode_e             RDW_MODE   = RDW_OLD_DATA,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input logic          clk,
  input logic          rst,
  dpram_rw_be_if.slave bus
);
  localparam int          AW      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [AW-1:0]         clr_addr;

  dpram_clr_seq #(
    .DATA_DEPTH (DATA_DEPTH),
    .AW         (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  logic                  rd_fire, wr_fire, rd_in_range, wr_in_range, collide;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_W;
  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_W;
  assign rd_fire     = !rst && !busy && bus.rd_en;
  assign wr_fire     = !rst && !busy && bus.wr_en && wr_in_range;
  assign collide     = wr_fire && (bus.wr_addr == bus.rd_addr);

  // Read-modify-write merge of the addressed word; also feeds the new-data bypass.
  assign wr_old    = mem[bus.wr_addr];
  assign wr_merged = DATA_WIDTH'(be_merge(MERGE_MAX_W'(wr_old), MERGE_MAX_W'(bus.wr_data),
                                          MERGE_MAX_W'(bus.wr_be), BYTE_WIDTH));

  // The clear sequencer owns the write port while busy.
  assign mem_we    = clr_we || wr_fire;
  assign mem_waddr = busy ? clr_addr  : bus.wr_addr;
  assign mem_wdata = busy ? CLEAR_VAL : wr_merged;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (!rd_in_range)
      rd_word = CLEAR_VAL;
    else if (RDW_MODE == RDW_NEW_DATA && collide)
      rd_word = wr_merged;
  end

  logic [DATA_WIDTH-1:0] arr_data;
  logic                  arr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      arr_data  <= '0;
      arr_valid <= 1'b0;
    end else begin
      arr_valid <= rd_fire;
      if (rd_fire) arr_data <= rd_word;
    end
  end

`ifdef DPRAM_RW_BE_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= arr_valid;
      if (arr_valid) out_data <= arr_data;
    end
  end

  assign bus.rd_data  = out_data;
  assign bus.rd_valid = out_valid;
`else
  assign bus.rd_data  = arr_data;
  assign bus.rd_valid = arr_valid;
`endif

endmodule

// File: tb/tb_dpram_rw_be.sv
// Bench for dpram_rw_be: two instances (old-data and new-data collision modes) share stimulus.
// Latency: follows the build (1 cycle, or 2 with DPRAM_RW_BE_OUTREG_EN).
// Backpressure: stimulus honours nothing; busy lockout is exercised on purpose.
module tb_dpram_rw_be;
  import dpram_pkg::*;

`ifdef DPRAM_RW_BE_OUTREG_EN
  localparam int          DEPTH = 200;
  localparam logic [31:0] CV    = 32'hCAFEF00D;
  localparam int          LAT   = 2;
`else
  localparam int          DEPTH = 256;
  localparam logic [31:0] CV    = 32'h0;
  localparam int          LAT   = 1;
`endif
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_rw_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH)) bus_o ();
  dpram_rw_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH)) bus_n ();

  assign bus_n.rd_en   = bus_o.rd_en;
  assign bus_n.rd_addr = bus_o.rd_addr;
  assign bus_n.wr_en   = bus_o.wr_en;
  assign bus_n.wr_be   = bus_o.wr_be;
  assign bus_n.wr_addr = bus_o.wr_addr;
  assign bus_n.wr_data = bus_o.wr_data;

  dpram_rw_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH),
                .RDW_MODE(RDW_OLD_DATA), .CLEAR_VAL(CV))
    u_dut_old (.clk(clk), .rst(rst), .bus(bus_o.slave));

  dpram_rw_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH),
                .RDW_MODE(RDW_NEW_DATA), .CLEAR_VAL(CV))
    u_dut_new (.clk(clk), .rst(rst), .bus(bus_n.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_busy   = 1'b1;
  int          m_cnt    = 0;
  bit          model_ok = 1'b0;
  bit          s1_v, s2_v;
  logic [31:0] s1_o, s1_n, s2_o, s2_n;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int l = 0; l < 4; l++)
      if (be[l]) m = m | (32'hFF << (8 * l));
    return m;
  endfunction

  always @(posedge clk) begin : model
    bit          v1;
    logic [31:0] d1o, d1n, old_w, msk;
    if (rst) begin
      m_busy = 1'b1; m_cnt = 0; model_ok = 1'b1;
      s1_v = 1'b0; s1_o = 32'h0; s1_n = 32'h0;
      s2_v = 1'b0; s2_o = 32'h0; s2_n = 32'h0;
    end else begin
      v1 = 1'b0; d1o = s1_o; d1n = s1_n;
      if (m_busy) begin
        m_mem[m_cnt] = CV;
        m_cnt++;
        if (m_cnt == DEPTH) m_busy = 1'b0;
      end else begin
        msk = lane_mask(bus_o.wr_be);
        if (bus_o.rd_en) begin
          v1 = 1'b1;
          if (int'(bus_o.rd_addr) >= DEPTH) begin
            d1o = CV; d1n = CV;
          end else begin
            old_w = m_mem[bus_o.rd_addr];
            d1o = old_w; d1n = old_w;
            if (bus_o.wr_en && bus_o.wr_addr == bus_o.rd_addr)
              d1n = (old_w & ~msk) | (bus_o.wr_data & msk);
          end
        end
        if (bus_o.wr_en && int'(bus_o.wr_addr) < DEPTH)
          m_mem[bus_o.wr_addr] = (m_mem[bus_o.wr_addr] & ~msk) | (bus_o.wr_data & msk);
      end
      s2_v = s1_v;
      if (s1_v) begin s2_o = s1_o; s2_n = s1_n; end
      s1_v = v1; s1_o = d1o; s1_n = d1n;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy_old",  32'(bus_o.busy),     32'(m_busy));
      chk("busy_new",  32'(bus_n.busy),     32'(m_busy));
      chk("valid_old", 32'(bus_o.rd_valid), 32'((LAT == 1) ? s1_v : s2_v));
      chk("valid_new", 32'(bus_n.rd_valid), 32'((LAT == 1) ? s1_v : s2_v));
      chk("data_old",  bus_o.rd_data,       (LAT == 1) ? s1_o : s2_o);
      chk("data_new",  bus_n.rd_data,       (LAT == 1) ? s1_n : s2_n);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    bus_o.wr_en = 1'b1; bus_o.wr_addr = AW'(a); bus_o.wr_data = d; bus_o.wr_be = be;
    cycle();
    bus_o.wr_en = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [31:0] exp_o, input logic [31:0] exp_n,
                         input string nm);
    bus_o.rd_en = 1'b1; bus_o.rd_addr = AW'(a);
    cycle();
    bus_o.rd_en = 1'b0;
    repeat (LAT - 1) cycle();
    @(negedge clk);
    chk({nm, "_vld"}, 32'(bus_o.rd_valid), 32'd1);
    chk({nm, "_old"}, bus_o.rd_data, exp_o);
    chk({nm, "_new"}, bus_n.rd_data, exp_n);
  endtask

  // Counts busy-high negedges; the ports are released after the third one.
  task automatic wait_clear(output int n);
    n = 0;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      @(negedge clk);
      if (!bus_o.busy) break;
      n++;
      if (n == 3) begin bus_o.wr_en = 1'b0; bus_o.rd_en = 1'b0; end
    end
  endtask

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin : main
    int          n;
    logic [31:0] pat;
    bus_o.rd_en = 1'b0; bus_o.rd_addr = '0;
    bus_o.wr_en = 1'b0; bus_o.wr_addr = '0; bus_o.wr_data = '0; bus_o.wr_be = '0;

    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    wait_clear(n);
    chk("busy_cycles", 32'(n), 32'(DEPTH));

    do_read(0,         CV, CV, "clr_0");
    do_read(127,       CV, CV, "clr_127");
    do_read(DEPTH - 1, CV, CV, "clr_last");

    do_write(5, 32'hDEADBEEF, 4'hF);
    do_write(5, 32'h11223344, 4'b0101);
    do_read(5, 32'hDE22BE44, 32'hDE22BE44, "be_mix");
    do_write(5, 32'h99999999, 4'h0);
    do_read(5, 32'hDE22BE44, 32'hDE22BE44, "be_zero");

    do_write(128, 32'hFFFFFFFF, 4'hF);
    bus_o.wr_en = 1'b1; bus_o.wr_addr = AW'(128); bus_o.wr_data = 32'h5A5A5A5A; bus_o.wr_be = 4'b0011;
    bus_o.rd_en = 1'b1; bus_o.rd_addr = AW'(128);
    cycle();
    bus_o.wr_en = 1'b0; bus_o.rd_en = 1'b0;
    repeat (LAT - 1) cycle();
    @(negedge clk);
    chk("coll_old", bus_o.rd_data, 32'hFFFFFFFF);
    chk("coll_new", bus_n.rd_data, 32'hFFFF5A5A);
    do_read(128, 32'hFFFF5A5A, 32'hFFFF5A5A, "coll_after");

    do_write(0, 32'hA5A5A5A5, 4'hF);
    do_read(0, 32'hA5A5A5A5, 32'hA5A5A5A5, "hold_rd");
    for (int a = 0; a < DEPTH; a++) begin
      bus_o.rd_addr = AW'(a);
      cycle();
      @(negedge clk);
      chk("hold_dat", bus_o.rd_data, 32'hA5A5A5A5);
      chk("hold_vld", 32'(bus_o.rd_valid), 32'd0);
    end

    for (int a = 0; a < DEPTH; a++)
      do_write(a, (a % 2 == 1) ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 4'hF);
    for (int a = 0; a < DEPTH; a++) begin
      pat = (a % 2 == 1) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      do_read(a, pat, pat, "stripe");
    end
    pat = (210 >= DEPTH) ? CV : 32'h5A5A5A5A;
    do_read(210, pat, pat, "addr_210");

    // Reset partway through the sweep, with a write and read attempted while locked out.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (100) cycle();
    rst = 1'b1;
    bus_o.wr_en = 1'b1; bus_o.wr_addr = AW'(3); bus_o.wr_data = 32'h12345678; bus_o.wr_be = 4'hF;
    bus_o.rd_en = 1'b1; bus_o.rd_addr = AW'(3);
    cycle();
    rst = 1'b0;
    wait_clear(n);
    chk("busy_restart", 32'(n), 32'(DEPTH));
    do_read(3, CV, CV, "lockout_rd");

    // Random traffic, biased towards a few addresses so collisions happen often.
    for (int c = 0; c < 1500; c++) begin
      bus_o.rd_en   = 1'($urandom_range(0, 1));
      bus_o.wr_en   = 1'($urandom_range(0, 1));
      bus_o.wr_be   = 4'($urandom_range(0, 15));
      bus_o.wr_data = $urandom;
      bus_o.rd_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      bus_o.wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      cycle();
    end
    bus_o.rd_en = 1'b0; bus_o.wr_en = 1'b0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dpram_rw_be.md
Name: dpram_rw_be

Overview:
- Simple dual-port RAM: one read port, one write port, single clock. Parametrised successor to the basic read/write DPRAM.
- Adds per-byte write enables, a selectable read-during-write mode and a post-reset hardware clear sequencer with a `busy` flag.
- Adds a `rd_valid` strobe.
- Used as generic buffer/table storage wherever software-visible or packet RAM needs a known initial state.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- DATA_DEPTH, 256, number of words; need not be a power of two.
- RDW_MODE, RDW_OLD_DATA, read-during-write result on an address collision: RDW_OLD_DATA or RDW_NEW_DATA.
- CLEAR_VAL, '0, DATA_WIDTH value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear sequence runs; both ports are ignored while high.
- rd_en  in  1  read request.
- rd_addr  in  $clog2(DATA_DEPTH)  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse when rd_data carries new read data.
- wr_en  in  1  write request.
- wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr  in  $clog2(DATA_DEPTH)  write address.
- wr_data  in  DATA_WIDTH  write data.

Behaviour:
- Reset is synchronous and active-high. Sampled high at a rising edge, it forces:
  - state = ST_CLEAR, clear counter = 0
  - rd_data = '0, rd_valid = 0, busy = 1
  - memory contents are not touched while rst is held.
- ST_CLEAR:
  - On each cycle with rst low, write CLEAR_VAL to mem[counter] and increment the counter.
  - After writing address DATA_DEPTH-1, go to ST_RUN. busy is low from the next cycle, i.e. DATA_DEPTH cycles after rst falls.
  - rd_en and wr_en are ignored; rd_valid stays 0.
  - rst asserted mid-clear restarts the sequence at address 0.
- ST_RUN, write port:
  - With wr_en high, lane i of mem[wr_addr] takes wr_data lane i when wr_be[i]=1.
  - Lanes with wr_be[i]=0 keep their old value; wr_be all-zero changes nothing.
- ST_RUN, read port:
  - With rd_en high, rd_data <= mem[rd_addr] at the edge, and rd_valid=1 for exactly the following cycle.
  - With rd_en low, rd_data holds its last value and rd_valid=0.
  - Latency: 1 cycle.
- Collision (rd_en & wr_en, same address, same edge):
  - RDW_OLD_DATA: rd_data = pre-write word.
  - RDW_NEW_DATA: rd_data = merged word — enabled lanes from wr_data, other lanes from the old word.
  - The memory is updated in both modes.
- Out of range (address >= DATA_DEPTH, possible only for non-power-of-two depths):
  - Writes are dropped.
  - Reads return CLEAR_VAL with rd_valid=1.
- Back-to-back reads and writes are allowed every cycle; there is no throttling in ST_RUN.

Optional Feature:
- Macro DPRAM_RW_BE_OUTREG_EN.
- Defined: one extra output register stage after the array.
  - Read latency is 2 cycles; rd_valid is delayed to align with rd_data.
  - The register holds its value when no new read emerges; reset clears it to '0.
  - Collision semantics are unchanged relative to the array read.
- Undefined: latency is 1 cycle as above.

Decomposition:
- Package dpram_pkg holds:
  - enum rdw_mode_e {RDW_OLD_DATA, RDW_NEW_DATA}
  - enum dpram_state_e {ST_CLEAR, ST_RUN}
  - function be_merge(old, new, be), shared by the write path and the RDW_NEW_DATA bypass.
- One natural sub-module, dpram_clr_seq: clear FSM plus address counter. It outputs busy, clr_we, clr_addr; the top muxes these onto the write port.

Test Plan (DATA_WIDTH=32, DATA_DEPTH=256, CLEAR_VAL=32'h0 unless noted):
- Clear: pulse rst for 2 cycles → busy=1 for exactly 256 cycles after rst falls. Then reading addresses 0, 127 and 255 gives 32'h0, with rd_valid asserted one cycle after each rd_en.
- Byte enables:
  - write(5, 32'hDEADBEEF, be=4'hF), then write(5, 32'h11223344, be=4'b0101) → read(5)=32'hDE22BE44.
  - be=4'h0 write leaves the word unchanged.
- Collision: mem[128]=32'hFFFFFFFF; same-cycle write(128, 32'h5A5A5A5A, be=4'b0011) and read(128) →
  - RDW_OLD_DATA: 32'hFFFFFFFF
  - RDW_NEW_DATA: 32'hFFFF5A5A
  - the following read gives 32'hFFFF5A5A in both modes.
- Read hold: read(0)=32'hA5A5A5A5, then sweep rd_addr 0..255 with rd_en=0 → rd_data stays 32'hA5A5A5A5 and rd_valid stays 0 throughout.
- Reset mid-clear and busy lockout:
  - Assert rst at clear count 100; issue a write of 32'h12345678 to address 3 while busy.
  - After the restart, busy lasts 256 cycles and read(3)=32'h0.
- Striping with the macro defined (and DATA_DEPTH=200, CLEAR_VAL=32'hCAFEF00D): write 32'h5A/32'hA5 patterns to 0..199, read them back → data matches with 2-cycle latency. read(210) returns 32'hCAFEF00D.
